uart_tx_fsm: RTL

Frame controller for the UART transmitter. It accepts a parallel byte handshake and sequences the TX serializer through start, data, optional parity and stop phases. It drives the serializer enable, the output-mux select and the busy flag. It sits between the upstream byte source and the serializer/output-mux datapath, and computes the parity bit for the frame.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_parity_calc.sv | 22 ++
 rtl/uart_tx_fsm.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states, output-mux codes and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b010,
    StParity = 3'b011,
    StStop   = 3'b100
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity bit for the frame: XOR-reduce of the byte, inverted for odd parity.
module uart_parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Capture parity on accept; hold it for the rest of the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^data) ^ par_typ;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame controller: sequences start, data, optional parity and stop phases.
// All outputs are registered and decoded from the next state.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [1:0]            mux_sel,
  output logic                  busy,
  output logic                  par_bit
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
  // Last DATA cycle index before the safety timeout forces STOP.
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH + 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            par_en_q;
  logic            accept;
  logic            ser_en_d, busy_d;
  logic [1:0]      mux_sel_d;

  assign accept = (state_q == StIdle) && Data_Valid;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .clk    (CLK),
    .rst    (RST),
    .load   (accept),
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .par_bit(par_bit)
  );

  // Next-state logic, including the DATA-phase safety counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (Data_Valid) state_d = StStart;
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        if (ser_done) begin
          state_d = par_en_q ? StParity : StStop;
        end else if (cnt_q == CntMax) begin
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: state_d = StStop;
      StStop:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the next state so registered outputs line up with their state.
  always_comb begin
    mux_sel_d = MUX_STOP;
    busy_d    = 1'b1;
    ser_en_d  = 1'b0;
    case (state_d)
      StStart:  mux_sel_d = MUX_START;
      StData: begin
        mux_sel_d = MUX_DATA;
        ser_en_d  = 1'b1;
      end
      StParity: mux_sel_d = MUX_PAR;
      StStop:   mux_sel_d = MUX_STOP;
      default:  busy_d    = 1'b0;
    endcase
  end

  // State, counter, latched parity enable and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      mux_sel  <= MUX_STOP;
      busy     <= 1'b0;
      ser_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) par_en_q <= PAR_EN;
      mux_sel <= mux_sel_d;
      busy    <= busy_d;
      ser_en  <= ser_en_d;
    end
  end

endmodule
